// File: rtl/mult_types.sv
// Shared multiply/divide types: operand width, RV32M funct3 codes, sequencer states,
// operand sign classes and the helpers that map a corrected product onto rd.
package mult_types;

  localparam int width_p = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Signed DIV/REM overflow: most negative dividend divided by -1.
  localparam logic [width_p-1:0] DIV_OVF_DIVIDEND = {1'b1, {(width_p-1){1'b0}}};
  localparam logic [width_p-1:0] DIV_OVF_DIVISOR  = '1;

  typedef enum logic [2:0] {
    MDCTL_IDLE,
    MDCTL_LAUNCH,
    MDCTL_BUSY,
    MDCTL_FIX,
    MDCTL_DRAIN,
    MDCTL_RESP
  } mdctl_state_e;

  typedef enum logic [1:0] {
    SC_SS,
    SC_SU,
    SC_UU
  } sign_class_e;

  function automatic sign_class_e class_of(input logic [2:0] f3);
    case (f3)
      F3_MULHSU: return SC_SU;
      F3_MULHU:  return SC_UU;
      default:   return SC_SS;
    endcase
  endfunction

  function automatic logic [width_p-1:0] select_result(input logic [2:0] f3,
                                                       input logic [2*width_p-1:0] full);
    if (f3 == F3_MUL || f3[2]) return full[width_p-1:0];
    return full[2*width_p-1:width_p];
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling around the unsigned unit: operand magnitudes and result
// sign on the way in, conditional negation and rd select on the way out.
module md_sign_fix
  import mult_types::*;
(
  input  logic [2:0]           op_funct3_i,
  input  logic [width_p-1:0]   rs1_i,
  input  logic [width_p-1:0]   rs2_i,
  output logic [width_p-1:0]   a_mag_o,
  output logic [width_p-1:0]   b_mag_o,
  output logic                 neg_o,
  output logic [2:0]           md_funct_o,
  input  logic [2:0]           fix_funct3_i,
  input  logic                 fix_neg_i,
  input  logic [2*width_p-1:0] raw_i,
  output logic [2*width_p-1:0] fixed_o,
  output logic [width_p-1:0]   result_o
);

  logic a_signed, b_signed, sign_a, sign_b;

  always_comb begin
    a_signed = op_funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = op_funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    sign_a   = a_signed & rs1_i[width_p-1];
    sign_b   = b_signed & rs2_i[width_p-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    a_mag_o  = sign_a ? -rs1_i : rs1_i;
    b_mag_o  = sign_b ? -rs2_i : rs2_i;
    neg_o    = (op_funct3_i inside {F3_REM, F3_REMU}) ? sign_a : (sign_a ^ sign_b);
    if (!op_funct3_i[2]) begin
      md_funct_o = F3_MULHU;
    end else if (op_funct3_i[1]) begin
      md_funct_o = F3_REMU;
    end else begin
      md_funct_o = F3_DIVU;
    end
    fixed_o  = fix_neg_i ? -raw_i : raw_i;
    result_o = select_result(fix_funct3_i, fixed_o);
  end

endmodule

// File: rtl/md_ctrl.sv
// RV32M sequencer: runs signed ops as unsigned unit runs with sign correction, answers
// divide special cases and repeated multiplies (one-entry product cache) without the unit.
module md_ctrl
  import mult_types::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  input  logic [2:0]           funct3_i,
  input  logic [width_p-1:0]   rs1_i,
  input  logic [width_p-1:0]   rs2_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 result_valid_o,
  output logic [width_p-1:0]   result_o,
  input  logic                 md_ready_i,
  input  logic                 md_done_i,
  input  logic [2*width_p-1:0] md_result_i,
  output logic                 md_start_o,
  output logic [2:0]           md_funct_o,
  output logic [width_p-1:0]   md_a_o,
  output logic [width_p-1:0]   md_b_o,
  output logic                 md_rst_n_o
);

  mdctl_state_e state_q, state_d;
  logic                 arm_q, neg_q, c_vld_q;
  logic [2:0]           f3_q, funct_q;
  logic [width_p-1:0]   a_q, b_q, rs1_q, rs2_q, result_q, c_rs1_q, c_rs2_q;
  logic [2*width_p-1:0] raw_q, c_prod_q;
  sign_class_e          c_cls_q;

  logic [width_p-1:0]   a_mag, b_mag, fix_res, quick_res;
  logic [2*width_p-1:0] fixed;
  logic [2:0]           unit_f3;
  logic                 neg, div_zero, ovf, hit, quick;

  md_sign_fix u_sign_fix (
    .op_funct3_i  (funct3_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .a_mag_o      (a_mag),
    .b_mag_o      (b_mag),
    .neg_o        (neg),
    .md_funct_o   (unit_f3),
    .fix_funct3_i (f3_q),
    .fix_neg_i    (neg_q),
    .raw_i        (raw_q),
    .fixed_o      (fixed),
    .result_o     (fix_res)
  );

  assign div_zero = funct3_i[2] & (rs2_i == '0);
  assign ovf      = ((funct3_i == F3_DIV) | (funct3_i == F3_REM)) &
                    (rs1_i == DIV_OVF_DIVIDEND) & (rs2_i == DIV_OVF_DIVISOR);
  // A MUL only needs the low half, which is identical for every signedness class.
  assign hit      = ~funct3_i[2] & c_vld_q & (rs1_i == c_rs1_q) & (rs2_i == c_rs2_q) &
                    ((class_of(funct3_i) == c_cls_q) | (funct3_i == F3_MUL));
  assign quick    = hit | div_zero | ovf;

  always_comb begin
    quick_res = select_result(funct3_i, c_prod_q);
    if (div_zero) begin
      quick_res = funct3_i[1] ? rs1_i : '1;
    end else if (ovf) begin
      quick_res = funct3_i[1] ? '0 : DIV_OVF_DIVIDEND;
    end
  end

  always_comb begin
    state_d        = state_q;
    md_start_o     = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      MDCTL_IDLE:   if (req_valid_i) state_d = quick ? MDCTL_RESP : MDCTL_LAUNCH;
      MDCTL_LAUNCH: begin
        if (flush_i) begin
          state_d = MDCTL_IDLE;
        end else if (arm_q && md_ready_i) begin
          md_start_o = 1'b1;
          state_d    = MDCTL_BUSY;
        end
      end
      MDCTL_BUSY: begin
        if (md_done_i) state_d = flush_i ? MDCTL_IDLE : MDCTL_FIX;
        else if (flush_i) state_d = MDCTL_DRAIN;
      end
      MDCTL_FIX:    state_d = flush_i ? MDCTL_IDLE : MDCTL_RESP;
      MDCTL_DRAIN:  if (md_done_i) state_d = MDCTL_IDLE;
      MDCTL_RESP: begin
        result_valid_o = ~flush_i;
        state_d        = MDCTL_IDLE;
      end
      default:      state_d = MDCTL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= MDCTL_IDLE;
      arm_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      funct_q  <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      raw_q    <= '0;
      result_q <= '0;
      c_vld_q  <= 1'b0;
      c_rs1_q  <= '0;
      c_rs2_q  <= '0;
      c_cls_q  <= SC_SS;
      c_prod_q <= '0;
    end else begin
      state_q <= state_d;
      // Launch waits one cycle in LAUNCH so the unit sees settled registered operands first.
      arm_q   <= (state_q == MDCTL_LAUNCH);
      if (state_q == MDCTL_IDLE && req_valid_i) begin
        if (quick) begin
          result_q <= quick_res;
        end else begin
          a_q     <= a_mag;
          b_q     <= b_mag;
          funct_q <= unit_f3;
          f3_q    <= funct3_i;
          neg_q   <= neg;
          rs1_q   <= rs1_i;
          rs2_q   <= rs2_i;
        end
      end
      if (state_q == MDCTL_BUSY && md_done_i) raw_q <= md_result_i;
      if (state_q == MDCTL_FIX && !flush_i) begin
        result_q <= fix_res;
        if (!f3_q[2]) begin
          c_vld_q  <= 1'b1;
          c_rs1_q  <= rs1_q;
          c_rs2_q  <= rs2_q;
          c_cls_q  <= class_of(f3_q);
          c_prod_q <= fixed;
        end
      end
    end
  end

  assign stall_o    = req_valid_i & ~result_valid_o;
  assign result_o   = result_q;
  assign md_a_o     = a_q;
  assign md_b_o     = b_q;
  assign md_funct_o = funct_q;
  assign md_rst_n_o = ~reset_i;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with a behavioural RV32M model and a latency-3 unsigned unit model.
module tb_md_ctrl;
  import mult_types::*;

  localparam int UNIT_LAT = 3;

  logic        clk_i, reset_i, req_valid_i, flush_i, md_ready_i, md_done_i;
  logic [2:0]  funct3_i, md_funct_o;
  logic [31:0] rs1_i, rs2_i, result_o, md_a_o, md_b_o;
  logic [63:0] md_result_i;
  logic        stall_o, result_valid_o, md_start_o, md_rst_n_o;

  int          n_checks = 0, n_fail = 0, cyc = 0, req_cyc = 0;
  int          start_q[$], done_q[$];
  logic [31:0] exp_res = '0, last_a = '0, last_b = '0;
  logic [2:0]  last_f = '0;
  bit          expect_valid = 0, in_rst_test = 0;

  md_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_valid_i(req_valid_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .stall_o(stall_o),
    .result_valid_o(result_valid_o), .result_o(result_o), .md_ready_i(md_ready_i),
    .md_done_i(md_done_i), .md_result_i(md_result_i), .md_start_o(md_start_o),
    .md_funct_o(md_funct_o), .md_a_o(md_a_o), .md_b_o(md_b_o), .md_rst_n_o(md_rst_n_o)
  );

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // RV32M rd value straight from the ISA definition.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    model = '0;
    case (f)
      3'd0: begin p = sa * sb; model = p[31:0]; end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; model = p[63:32]; end
      3'd4: begin
        if (b == 0) model = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = 32'h80000000;
        else model = ia / ib;
      end
      3'd5: model = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) model = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = 32'h0;
        else model = ia % ib;
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Unsigned iterative unit: ready drops after a start, done pulses UNIT_LAT cycles later.
  initial begin
    logic [31:0] ua, ub;
    logic [2:0]  uf;
    md_ready_i  = 1;
    md_done_i   = 0;
    md_result_i = '0;
    forever begin
      @(negedge clk_i);
      if (md_start_o && !reset_i) begin
        ua = md_a_o; ub = md_b_o; uf = md_funct_o;
        last_a = ua; last_b = ub; last_f = uf;
        start_q.push_back(cyc);
        @(posedge clk_i); #1;
        md_ready_i = 0;
        repeat (UNIT_LAT) @(posedge clk_i);
        #1;
        if (!in_rst_test) begin
          check("unit_a_stable", md_a_o, ua);
          check("unit_b_stable", md_b_o, ub);
          check("unit_f_stable", md_funct_o, uf);
        end
        case (uf)
          3'd3:    md_result_i = {32'h0, ua} * {32'h0, ub};
          3'd5:    md_result_i = {32'h0, ua / ub};
          default: md_result_i = {32'h0, ua % ub};
        endcase
        md_done_i = 1;
        done_q.push_back(cyc);
        @(posedge clk_i); #1;
        md_done_i  = 0;
        md_ready_i = 1;
      end
    end
  end

  // Per-cycle protocol and result checks.
  initial begin
    bit prev_start = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        prev_start = 0;
      end else begin
        check("stall", stall_o, req_valid_i & ~result_valid_o);
        if (md_start_o) begin
          check("start_needs_ready", md_ready_i, 1);
          check("start_back_to_back", prev_start, 0);
        end
        prev_start = md_start_o;
        if (!expect_valid) check("no_result_valid", result_valid_o, 0);
        else if (result_valid_o) check("result_vs_model", result_o, exp_res);
      end
    end
  end

  task automatic check_zero(input string nm);
    @(negedge clk_i);
    check({nm, "_valid"}, result_valid_o, 0);
    check({nm, "_start"}, md_start_o, 0);
    check({nm, "_stall"}, stall_o, 0);
    check({nm, "_result"}, result_o, 0);
    check({nm, "_a"}, md_a_o, 0);
    check({nm, "_b"}, md_b_o, 0);
    check({nm, "_funct"}, md_funct_o, 0);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_res = model(f, a, b);
    expect_valid = 1;
    funct3_i = f; rs1_i = a; rs2_i = b;
    req_valid_i = 1;
    req_cyc = cyc;
  endtask

  task automatic wait_res(input string nm, input logic [31:0] lit, input bit fast, input int starts0);
    bit seen = 0;
    int lat = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (result_valid_o) begin
        seen = 1;
        lat = cyc - req_cyc;
      end
    end
    check({nm, "_seen"}, seen, 1);
    if (seen) begin
      check({nm, "_res"}, result_o, lit);
      check({nm, "_model"}, model(funct3_i, rs1_i, rs2_i), lit);
      if (fast) begin
        check({nm, "_lat"}, lat, 1);
        check({nm, "_nostart"}, start_q.size(), starts0);
      end else begin
        check({nm, "_one_start"}, start_q.size(), starts0 + 1);
        if (start_q.size() > 0 && done_q.size() > 0) begin
          check({nm, "_done_to_valid"}, cyc - done_q[$], 2);
          check({nm, "_start_ge2"}, (start_q[$] - req_cyc) >= 2, 1);
        end
      end
    end
    @(posedge clk_i); #1;
    req_valid_i = 0;
    expect_valid = 0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input bit fast);
    int s0;
    s0 = start_q.size();
    @(posedge clk_i); #1;
    issue(f, a, b);
    wait_res(nm, lit, fast, s0);
  endtask

  task automatic wait_start(input string nm, input int k);
    for (int i = 0; i < 50 && start_q.size() == k; i++) @(negedge clk_i);
    check({nm, "_started"}, start_q.size(), k + 1);
  endtask

  initial begin
    int k;
    reset_i = 1; req_valid_i = 0; flush_i = 0; funct3_i = 0; rs1_i = 0; rs2_i = 0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 0;
    check_zero("reset");

    run_op("mul_neg", F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    check("mul_neg_unit_funct", last_f, 3);
    check("mul_neg_unit_a", last_a, 7);
    check("mul_neg_unit_b", last_b, 3);
    run_op("mulh_min", F3_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op("mul_hit", F3_MUL, 32'h80000000, 32'h80000000, 32'h00000000, 1);
    run_op("mulhu_cls_miss", F3_MULHU, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0);
    run_op("div_neg", F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0);
    run_op("rem_neg", F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0);
    run_op("divu_zero", F3_DIVU, 32'h00001234, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_zero", F3_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush while BUSY, next request presented during the drain.
    k = start_q.size();
    @(posedge clk_i); #1;
    funct3_i = F3_MULHU; rs1_i = 32'd3; rs2_i = 32'd5; req_valid_i = 1;
    wait_start("flush_run", k);
    @(posedge clk_i); #1;
    flush_i = 1; req_valid_i = 0;
    @(posedge clk_i); #1;
    flush_i = 0;
    issue(F3_MULHU, 32'hFFFFFFFF, 32'd2);
    wait_res("mulhu_after_flush", 32'd1, 0, k + 1);
    if (start_q.size() > k + 1 && done_q.size() > k)
      check("drain_before_restart", start_q[k + 1] >= done_q[k] + 3, 1);
    run_op("flushed_not_cached", F3_MULHU, 32'd3, 32'd5, 32'd0, 0);

    // Reset while BUSY.
    in_rst_test = 1;
    k = start_q.size();
    @(posedge clk_i); #1;
    funct3_i = F3_DIVU; rs1_i = 32'd100; rs2_i = 32'd7; req_valid_i = 1;
    wait_start("rst_run", k);
    @(posedge clk_i); #1;
    reset_i = 1; req_valid_i = 0;
    @(posedge clk_i); #1;
    reset_i = 0;
    check_zero("rst_busy");
    for (int i = 0; i < 50 && done_q.size() == k; i++) @(negedge clk_i);
    repeat (3) @(posedge clk_i);
    in_rst_test = 0;
    run_op("mul_after_rst", F3_MUL, 32'd3, 32'd5, 32'd15, 0);

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end before 20000", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
